// File: rtl/vga_genlock_pkg.sv
// Shared types and widths for the vga_genlock reference-tracking controller.
// Optional feature macro: VGA_GENLOCK_FILTER_EN (glitch filter on ref_sync).
package vga_genlock_pkg;

    localparam int TICK_W = 20;
    localparam int ERR_W  = 21;

    typedef enum logic [1:0] {
        NOREF   = 2'd0,
        MEASURE = 2'd1,
        TRACK   = 2'd2
    } state_t;

    function automatic logic [ERR_W-1:0] abs_err(
        input logic signed [ERR_W-1:0] e
    );
        return e[ERR_W-1] ? -e : e;
    endfunction

endpackage

// File: rtl/genlock_sync_edge.sv
// Synchronizer, optional glitch filter and rising-edge detector for ref_sync.
// The filter is compiled in only when VGA_GENLOCK_FILTER_EN is defined.
module genlock_sync_edge
    import vga_genlock_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int FILTER_TICKS = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_async,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;
    logic                   w_level;
    logic                   r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else if (i_en) begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef VGA_GENLOCK_FILTER_EN
    localparam int FCW = $clog2(FILTER_TICKS + 1);

    logic [FCW-1:0] r_fcnt;
    logic           r_filt;

    // Level flips only after the new value has held for FILTER_TICKS ticks.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fcnt <= '0;
            r_filt <= 1'b0;
        end else if (i_en) begin
            if (w_sync == r_filt) begin
                r_fcnt <= '0;
            end else if (r_fcnt == FCW'(FILTER_TICKS - 1)) begin
                r_filt <= w_sync;
                r_fcnt <= '0;
            end else begin
                r_fcnt <= r_fcnt + 1'b1;
            end
        end
    end

    assign w_level = r_filt;
`else
    logic w_unused_ft;

    assign w_unused_ft = (FILTER_TICKS > 0);
    assign w_level     = w_sync;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev <= 1'b0;
        end else if (i_en) begin
            r_prev <= w_level;
        end
    end

    assign o_rise = w_level & ~r_prev;

endmodule

// File: rtl/vga_genlock.sv
// Genlock controller: measures ref_sync period and VGA_VSYNC phase, fires genlock.
// Define VGA_GENLOCK_FILTER_EN to insert a glitch filter on the reference input.
module vga_genlock
    import vga_genlock_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int PERIOD_MIN   = 320000,
    parameter int PERIOD_MAX   = 345000,
    parameter int VSYNC_OFFSET = 316803,
    parameter int PHASE_TOL    = 264,
    parameter int LOCK_COUNT   = 4,
    parameter int FILTER_TICKS = 8
) (
    input  logic                    vga_clk,
    input  logic                    rst_n,
    input  logic                    vga_clk_en,
    input  logic                    ref_sync,
    input  logic                    vga_vsync,
    output logic                    genlock,
    output logic                    locked,
    output logic [TICK_W-1:0]       ref_period,
    output logic signed [ERR_W-1:0] phase_err
);

    localparam int GC_W = $clog2(LOCK_COUNT + 1);
    localparam logic [TICK_W-1:0] TICK_SAT = TICK_W'(PERIOD_MAX + 1);

    logic                    w_ref_rise;
    logic                    w_ref_edge;
    logic                    w_vs_edge;
    logic                    w_sat;
    logic                    w_period_ok;
    logic                    w_phase_ok;
    logic signed [ERR_W-1:0] w_err;

    logic                    r_vs_prev;
    logic [TICK_W-1:0]       r_tick_cnt;
    logic [TICK_W-1:0]       r_vs_off;
    logic                    r_vs_seen;
    logic [TICK_W-1:0]       r_ref_period;
    logic signed [ERR_W-1:0] r_phase_err;

    state_t                  r_state;
    logic [GC_W-1:0]         r_good_cnt;
    logic                    r_locked;
    logic                    r_genlock;

    genlock_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_TICKS(FILTER_TICKS)
    ) u_ref_edge (
        .i_clk  (vga_clk),
        .i_rst_n(rst_n),
        .i_en   (vga_clk_en),
        .i_async(ref_sync),
        .o_rise (w_ref_rise)
    );

    assign w_ref_edge  = vga_clk_en & w_ref_rise;
    assign w_vs_edge   = vga_clk_en & vga_vsync & ~r_vs_prev;
    assign w_sat       = (r_tick_cnt == TICK_SAT);
    assign w_period_ok = (r_tick_cnt >= TICK_W'(PERIOD_MIN)) &&
                         (r_tick_cnt <= TICK_W'(PERIOD_MAX));
    assign w_err       = $signed({1'b0, r_vs_off}) - ERR_W'(VSYNC_OFFSET);
    assign w_phase_ok  = r_vs_seen &&
                         (abs_err(w_err) <= ERR_W'(PHASE_TOL));

    // tick_cnt reads as ticks elapsed since the last ref_edge tick,
    // so at the next edge it holds the full period.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_prev    <= 1'b0;
            r_tick_cnt   <= '0;
            r_vs_off     <= '0;
            r_vs_seen    <= 1'b0;
            r_ref_period <= '0;
            r_phase_err  <= '0;
        end else if (vga_clk_en) begin
            r_vs_prev <= vga_vsync;
            if (w_ref_edge) begin
                r_tick_cnt   <= TICK_W'(1);
                r_ref_period <= r_tick_cnt;
                r_vs_seen    <= w_vs_edge;
                if (r_vs_seen) begin
                    r_phase_err <= w_err;
                end
                if (w_vs_edge) begin
                    r_vs_off <= '0;
                end
            end else begin
                if (!w_sat) begin
                    r_tick_cnt <= r_tick_cnt + 1'b1;
                end
                if (w_vs_edge && !r_vs_seen) begin
                    r_vs_off  <= r_tick_cnt;
                    r_vs_seen <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= NOREF;
            r_good_cnt <= '0;
            r_locked   <= 1'b0;
            r_genlock  <= 1'b0;
        end else if (vga_clk_en) begin
            r_genlock <= 1'b0;
            unique case (r_state)
                NOREF: begin
                    if (w_ref_edge) begin
                        r_state <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (w_ref_edge) begin
                        if (w_period_ok) begin
                            r_genlock  <= 1'b1;
                            r_good_cnt <= '0;
                            r_state    <= TRACK;
                        end
                    end else if (w_sat) begin
                        r_state <= NOREF;
                    end
                end
                TRACK: begin
                    if (w_ref_edge) begin
                        if (!w_period_ok) begin
                            r_state  <= MEASURE;
                            r_locked <= 1'b0;
                        end else if (w_phase_ok) begin
                            if (r_good_cnt != GC_W'(LOCK_COUNT)) begin
                                r_good_cnt <= r_good_cnt + 1'b1;
                            end
                            r_locked <= (r_good_cnt >= GC_W'(LOCK_COUNT - 1));
                        end else begin
                            r_genlock  <= 1'b1;
                            r_good_cnt <= '0;
                            r_locked   <= 1'b0;
                        end
                    end else if (w_sat) begin
                        r_state  <= NOREF;
                        r_locked <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= NOREF;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign genlock    = r_genlock;
    assign locked     = r_locked;
    assign ref_period = r_ref_period;
    assign phase_err  = r_phase_err;

endmodule
